mem_ctrl: RTL

- Initiator side of the byte-wide ROM/RAM memory bus: converts single CPU read/write requests into timed bus cycles on wr_en, rd_en, rom_ram, address_bus and the shared bidirectional data_bus.
- Sits between the CPU load/store unit and the 32K ROM / 32K RAM devices.
- Owns bus timing (setup, wait states, turnaround), so no two drivers ever contend on data_bus.

---
 rtl/mem_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide ROM/RAM bus initiator.
// Turns single CPU requests into timed read/write bus cycles.
module mem_ctrl #(
    parameter int ACTION   = 1,
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    output logic        wr_en,
    output logic        rd_en,
    output logic        rom_ram,
    output logic [14:0] address_bus,
    inout  wire  [7:0]  data_bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] TURN  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

    logic [2:0] state;
    logic [2:0] state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic       we_q;
    logic [7:0] wdata_q;
    logic       drive;
    logic       rom_wr;

    assign rom_wr = req_we && !req_addr[15] && (ACTION == 0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n = rom_wr ? ERR : SETUP;
                end
            end
            SETUP: begin
                state_n = we_q ? WRITE : READ;
                cnt_n   = we_q ? WR_LOAD : RD_LOAD;
            end
            READ: begin
                if (cnt == 4'd0) begin
                    state_n = TURN;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            WRITE: begin
                if (cnt == 4'd0) begin
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD, TURN, ERR: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            wdata_q     <= 8'h00;
            drive       <= 1'b0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 8'h00;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            rom_ram     <= 1'b0;
            address_bus <= 15'h0000;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req_ready  <= (state_n == IDLE);
            resp_valid <= (state_n == HOLD) || (state_n == TURN) ||
                          (state_n == ERR);
            resp_err   <= (state_n == ERR);
            rd_en      <= (state_n == READ);
            wr_en      <= (state_n == WRITE);
            // SETUP is only entered from IDLE, so req_we is the live value.
            drive      <= ((state_n == SETUP) && req_we) ||
                          (state_n == WRITE) || (state_n == HOLD);
            if (state == IDLE && req_valid) begin
                we_q        <= req_we;
                wdata_q     <= req_wdata;
                address_bus <= req_addr[14:0];
                rom_ram     <= req_addr[15];
            end
            if (state == READ && cnt == 4'd0) begin
                resp_rdata <= data_bus;
            end
        end
    end

    assign data_bus = drive ? wdata_q : 8'hzz;

endmodule
